// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
// Covers the FSM state encoding, the default timeout and the MEM/WB bundle widths.
package mem_access_stage_pkg;

    localparam int ARQ_W           = 16;
    localparam int REG_W           = 3;
    localparam int TIMEOUT_DEFAULT = 255;
    localparam int CTR_W           = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/grant/rvalid bus between the memory-access stage and the memory.
// The stage is the master; the memory model or controller is the slave.
interface mem_access_stage_if #(
    parameter int ARQ = 16
);
    logic           mem_req;
    logic           mem_we;
    logic [ARQ-1:0] mem_addr;
    logic [ARQ-1:0] mem_wdata;
    logic           mem_gnt;
    logic           mem_rvalid;
    logic [ARQ-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_access_stage_timeout_ctr.sv
// Clear/enable cycle counter with a terminal-count flag.
// tc is high while the counter holds LIMIT-1, i.e. during the LIMIT-th enabled cycle.
module mem_timeout_ctr #(
    parameter int WIDTH = 16,
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign tc = (count_q == LAST);

    // Hold at the terminal value so the flag cannot wrap if enable lingers.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !tc) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: runs loads/stores over the req/gnt/rvalid bus,
// stalls upstream while an access is outstanding and registers the MEM/WB outputs.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int ARQ     = ARQ_W,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_enable_in,
    input  logic             rd_mem_en,
    input  logic             wr_mem_en,
    input  logic             mux_mem_in,
    input  logic             pc_en_in,
    input  logic [ARQ-1:0]   src1_in,
    input  logic [ARQ-1:0]   srcdest_in,
    input  logic [ARQ-1:0]   alu_result_in,
    input  logic [ARQ-1:0]   wb_imm_in,
    input  logic [REG_W-1:0] wb_dest_in,
    output logic             stall_out,
    mem_access_stage_if.master mem,
    output logic             wb_enable_out,
    output logic             pc_en_out,
    output logic [ARQ-1:0]   wb_data_out,
    output logic [ARQ-1:0]   wb_imm_out,
    output logic [REG_W-1:0] wb_dest_out,
    output logic             mem_err
);
    mem_state_t       state_q, state_d;
    logic [ARQ-1:0]   addr_q, addr_d, wdata_q, wdata_d, imm_lat_q, imm_lat_d;
    logic [REG_W-1:0] dest_lat_q, dest_lat_d;
    logic             we_q, we_d, wb_en_lat_q, wb_en_lat_d;
    logic             mux_lat_q, mux_lat_d, pc_en_lat_q, pc_en_lat_d;
    logic             wb_en_q, wb_en_d, pc_en_q, pc_en_d, err_q, err_d;
    logic [ARQ-1:0]   wb_data_q, wb_data_d, wb_imm_q, wb_imm_d;
    logic [REG_W-1:0] wb_dest_q, wb_dest_d;
    logic             tmo_tc;
    logic             unused_src1;

    assign unused_src1 = ^src1_in;

    mem_timeout_ctr #(
        .WIDTH (CTR_W),
        .LIMIT (TIMEOUT)
    ) u_timeout_ctr (
        .clk (clk),
        .rst (rst),
        .clr (state_q == IDLE),
        .en  (state_q != IDLE),
        .tc  (tmo_tc)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        dest_lat_d  = dest_lat_q;
        wb_en_lat_d = wb_en_lat_q;
        mux_lat_d   = mux_lat_q;
        pc_en_lat_d = pc_en_lat_q;
        imm_lat_d   = imm_lat_q;
        wb_en_d     = wb_en_q;
        pc_en_d     = pc_en_q;
        wb_data_d   = wb_data_q;
        wb_imm_d    = wb_imm_q;
        wb_dest_d   = wb_dest_q;
        err_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rd_mem_en && wr_mem_en) begin
                    // Illegal combination retires as a killed non-memory op.
                    err_d     = 1'b1;
                    wb_en_d   = 1'b0;
                    pc_en_d   = 1'b0;
                    wb_data_d = alu_result_in;
                    wb_imm_d  = wb_imm_in;
                    wb_dest_d = wb_dest_in;
                end else if (rd_mem_en || wr_mem_en) begin
                    addr_d      = alu_result_in;
                    wdata_d     = srcdest_in;
                    we_d        = wr_mem_en;
                    dest_lat_d  = wb_dest_in;
                    wb_en_lat_d = wb_enable_in;
                    mux_lat_d   = mux_mem_in;
                    pc_en_lat_d = pc_en_in;
                    imm_lat_d   = wb_imm_in;
                    wb_en_d     = 1'b0;
                    pc_en_d     = 1'b0;
                    state_d     = REQ;
                end else begin
                    wb_en_d   = wb_enable_in;
                    pc_en_d   = pc_en_in;
                    wb_data_d = alu_result_in;
                    wb_imm_d  = wb_imm_in;
                    wb_dest_d = wb_dest_in;
                end
            end
            REQ: begin
                if (mem.mem_gnt) begin
                    if (we_q) begin
                        wb_en_d   = wb_en_lat_q;
                        pc_en_d   = pc_en_lat_q;
                        wb_data_d = addr_q;
                        wb_imm_d  = imm_lat_q;
                        wb_dest_d = dest_lat_q;
                        state_d   = IDLE;
                    end else begin
                        state_d = WAIT_R;
                    end
                end else if (tmo_tc) begin
                    err_d   = 1'b1;
                    wb_en_d = 1'b0;
                    pc_en_d = 1'b0;
                    state_d = IDLE;
                end
            end
            WAIT_R: begin
                if (mem.mem_rvalid) begin
                    wb_en_d   = wb_en_lat_q;
                    pc_en_d   = pc_en_lat_q;
                    wb_data_d = mux_lat_q ? mem.mem_rdata : addr_q;
                    wb_imm_d  = imm_lat_q;
                    wb_dest_d = dest_lat_q;
                    state_d   = IDLE;
                end else if (tmo_tc) begin
                    err_d   = 1'b1;
                    wb_en_d = 1'b0;
                    pc_en_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            dest_lat_q  <= '0;
            wb_en_lat_q <= 1'b0;
            mux_lat_q   <= 1'b0;
            pc_en_lat_q <= 1'b0;
            imm_lat_q   <= '0;
            wb_en_q     <= 1'b0;
            pc_en_q     <= 1'b0;
            wb_data_q   <= '0;
            wb_imm_q    <= '0;
            wb_dest_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            dest_lat_q  <= dest_lat_d;
            wb_en_lat_q <= wb_en_lat_d;
            mux_lat_q   <= mux_lat_d;
            pc_en_lat_q <= pc_en_lat_d;
            imm_lat_q   <= imm_lat_d;
            wb_en_q     <= wb_en_d;
            pc_en_q     <= pc_en_d;
            wb_data_q   <= wb_data_d;
            wb_imm_q    <= wb_imm_d;
            wb_dest_q   <= wb_dest_d;
            err_q       <= err_d;
        end
    end

    // Request fields come straight from the latches, so they stay stable until gnt.
    assign mem.mem_req   = (state_q == REQ);
    assign mem.mem_we    = (state_q == REQ) && we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    assign stall_out     = (state_q != IDLE);
    assign wb_enable_out = wb_en_q;
    assign pc_en_out     = pc_en_q;
    assign wb_data_out   = wb_data_q;
    assign wb_imm_out    = wb_imm_q;
    assign wb_dest_out   = wb_dest_q;
    assign mem_err       = err_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed and randomized checks of mem_access_stage against a transaction-level model.
// A second instance with a short timeout and a silent memory covers the abort path.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    localparam int T       = 6;
    localparam int T_SHORT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_enable_in, rd_mem_en, wr_mem_en, mux_mem_in, pc_en_in;
    logic [15:0] src1_in, srcdest_in, alu_result_in, wb_imm_in;
    logic [2:0]  wb_dest_in;

    logic        stall_out, wb_enable_out, pc_en_out, mem_err;
    logic [15:0] wb_data_out, wb_imm_out;
    logic [2:0]  wb_dest_out;
    logic        t_stall_out, t_wb_enable_out, t_pc_en_out, t_mem_err;
    logic [15:0] t_wb_data_out, t_wb_imm_out;
    logic [2:0]  t_wb_dest_out;

    typedef struct {
        logic        en;
        logic        pc;
        logic [15:0] data;
        logic [15:0] imm;
        logic [2:0]  dest;
        logic        err;
    } wb_t;

    wb_t exp;
    int  checks = 0;
    int  errors = 0;

    always #5 clk = ~clk;

    mem_access_stage_if #(.ARQ(16)) m ();
    mem_access_stage_if #(.ARQ(16)) mt ();

    mem_access_stage #(.ARQ(16), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .wb_enable_in(wb_enable_in), .rd_mem_en(rd_mem_en), .wr_mem_en(wr_mem_en),
        .mux_mem_in(mux_mem_in), .pc_en_in(pc_en_in),
        .src1_in(src1_in), .srcdest_in(srcdest_in), .alu_result_in(alu_result_in),
        .wb_imm_in(wb_imm_in), .wb_dest_in(wb_dest_in),
        .stall_out(stall_out), .mem(m.master),
        .wb_enable_out(wb_enable_out), .pc_en_out(pc_en_out), .wb_data_out(wb_data_out),
        .wb_imm_out(wb_imm_out), .wb_dest_out(wb_dest_out), .mem_err(mem_err)
    );

    mem_access_stage #(.ARQ(16), .TIMEOUT(T_SHORT)) dut_t (
        .clk(clk), .rst(rst),
        .wb_enable_in(wb_enable_in), .rd_mem_en(rd_mem_en), .wr_mem_en(wr_mem_en),
        .mux_mem_in(mux_mem_in), .pc_en_in(pc_en_in),
        .src1_in(src1_in), .srcdest_in(srcdest_in), .alu_result_in(alu_result_in),
        .wb_imm_in(wb_imm_in), .wb_dest_in(wb_dest_in),
        .stall_out(t_stall_out), .mem(mt.master),
        .wb_enable_out(t_wb_enable_out), .pc_en_out(t_pc_en_out), .wb_data_out(t_wb_data_out),
        .wb_imm_out(t_wb_imm_out), .wb_dest_out(t_wb_dest_out), .mem_err(t_mem_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_wb_en"}, wb_enable_out, exp.en);
        chk({tag, "_pc_en"}, pc_en_out, exp.pc);
        chk({tag, "_data"},  wb_data_out, exp.data);
        chk({tag, "_imm"},   wb_imm_out, exp.imm);
        chk({tag, "_dest"},  wb_dest_out, exp.dest);
        chk({tag, "_err"},   mem_err, exp.err);
        chk({tag, "_stall"}, stall_out, 1'b0);
        chk({tag, "_req"},   m.mem_req, 1'b0);
    endtask

    // One pipeline transaction; gd = cycles without gnt before the grant, rdl = same for rvalid.
    task automatic do_op(input string tag, input bit rd, input bit wr, input bit mux,
                         input bit wen, input bit pce, input logic [15:0] alu,
                         input logic [15:0] sd, input logic [15:0] imm, input logic [2:0] dest,
                         input int gd, input int rdl, input logic [15:0] rdata);
        int  cyc, w, total;
        bit  in_req;
        chk({tag, "_idle_before"}, stall_out, 1'b0);
        rd_mem_en = rd; wr_mem_en = wr; mux_mem_in = mux; wb_enable_in = wen; pc_en_in = pce;
        alu_result_in = alu; srcdest_in = sd; wb_imm_in = imm; wb_dest_in = dest;
        src1_in = 16'($urandom);
        @(negedge clk);
        if (rd && wr) begin
            exp.en = 1'b0; exp.pc = 1'b0; exp.data = alu; exp.imm = imm; exp.dest = dest;
            exp.err = 1'b1;
        end else if (!rd && !wr) begin
            exp.en = wen; exp.pc = pce; exp.data = alu; exp.imm = imm; exp.dest = dest;
            exp.err = 1'b0;
        end else begin
            // Upstream contents are ignored while stalled, so present junk non-memory ops.
            rd_mem_en = 1'b0; wr_mem_en = 1'b0; wb_enable_in = 1'($urandom);
            alu_result_in = 16'($urandom); wb_imm_in = 16'($urandom);
            cyc = 0; w = 0; in_req = 1'b1;
            while (stall_out === 1'b1 && cyc < 64) begin
                cyc++;
                chk({tag, "_req_phase"}, m.mem_req, in_req);
                if (in_req) begin
                    chk({tag, "_addr"},  m.mem_addr, alu);
                    chk({tag, "_we"},    m.mem_we, wr);
                    chk({tag, "_wdata"}, m.mem_wdata, sd);
                end
                chk({tag, "_bubble"}, wb_enable_out, 1'b0);
                chk({tag, "_hold"},   wb_data_out, exp.data);
                chk({tag, "_noerr"},  mem_err, 1'b0);
                if (in_req) begin
                    m.mem_gnt = (w == gd);
                    m.mem_rvalid = 1'($urandom);
                    if (w == gd && rd) begin in_req = 1'b0; w = 0; end
                    else w++;
                end else begin
                    m.mem_gnt = 1'($urandom);
                    m.mem_rvalid = (w == rdl);
                    m.mem_rdata = (w == rdl) ? rdata : 16'($urandom);
                    w++;
                end
                @(negedge clk);
            end
            m.mem_gnt = 1'b0; m.mem_rvalid = 1'b0;
            total = wr ? gd + 1 : gd + rdl + 2;
            chk({tag, "_stall_cycles"}, cyc, (total > T) ? T : total);
            if (total > T) begin
                exp.en = 1'b0; exp.pc = 1'b0; exp.err = 1'b1;
            end else begin
                exp.en = wen; exp.pc = pce; exp.imm = imm; exp.dest = dest; exp.err = 1'b0;
                exp.data = (rd && mux) ? rdata : alu;
            end
        end
        chk_outputs(tag);
    endtask

    task automatic watch_short();
        int c = 0;
        @(negedge clk);
        while (t_stall_out === 1'b1 && c < 20) begin
            c++;
            chk("tmo_req", mt.mem_req, 1'b1);
            chk("tmo_err_low", t_mem_err, 1'b0);
            @(negedge clk);
        end
        chk("tmo_cycles", c, T_SHORT);
        chk("tmo_err", t_mem_err, 1'b1);
        chk("tmo_wb_en", t_wb_enable_out, 1'b0);
        chk("tmo_pc_en", t_pc_en_out, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind;
        wb_enable_in = 0; rd_mem_en = 0; wr_mem_en = 0; mux_mem_in = 0; pc_en_in = 0;
        src1_in = 0; srcdest_in = 0; alu_result_in = 0; wb_imm_in = 0; wb_dest_in = 0;
        m.mem_gnt = 0; m.mem_rvalid = 0; m.mem_rdata = 0;
        mt.mem_gnt = 0; mt.mem_rvalid = 0; mt.mem_rdata = 0;
        exp.en = 0; exp.pc = 0; exp.data = 0; exp.imm = 0; exp.dest = 0; exp.err = 0;

        repeat (2) @(negedge clk);
        chk_outputs("reset");
        chk("reset_we", m.mem_we, 1'b0);
        rst = 1'b1;

        do_op("nonmem", 0, 0, 0, 1, 1, 16'h1234, 16'h0, 16'h0011, 3'd3, 0, 0, 16'h0);

        fork
            do_op("timeout", 1, 0, 1, 1, 1, 16'h0100, 16'h5555, 16'h0007, 3'd5, 99, 0, 16'h0);
            watch_short();
        join
        do_op("after_tmo", 0, 0, 0, 1, 0, 16'h2222, 16'h0, 16'h0033, 3'd6, 0, 0, 16'h0);
        chk("after_tmo_t_data", t_wb_data_out, 16'h2222);
        chk("after_tmo_t_en", t_wb_enable_out, 1'b1);
        chk("after_tmo_t_err", t_mem_err, 1'b0);

        do_op("store", 0, 1, 0, 1, 1, 16'h0040, 16'hBEEF, 16'h0044, 3'd1, 0, 0, 16'h0);
        do_op("load_wait", 1, 0, 1, 1, 1, 16'h0080, 16'h0, 16'h0055, 3'd2, 2, 2, 16'hA5A5);
        do_op("illegal", 1, 1, 1, 1, 1, 16'h0900, 16'h1111, 16'h0066, 3'd4, 0, 0, 16'h0);
        do_op("post_illegal", 0, 0, 0, 1, 1, 16'h0901, 16'h0, 16'h0067, 3'd7, 0, 0, 16'h0);

        // Reset while a load is waiting for read data.
        chk("rst_idle", stall_out, 1'b0);
        rd_mem_en = 1; wr_mem_en = 0; mux_mem_in = 1; wb_enable_in = 1; pc_en_in = 1;
        alu_result_in = 16'h0300; wb_dest_in = 3'd2; wb_imm_in = 16'h0077;
        @(negedge clk);
        rd_mem_en = 0; m.mem_gnt = 1;
        @(negedge clk);
        m.mem_gnt = 0;
        chk("rst_in_wait_r", stall_out, 1'b1);
        rst = 1'b0;
        #1;
        exp.en = 0; exp.pc = 0; exp.data = 0; exp.imm = 0; exp.dest = 0; exp.err = 0;
        chk_outputs("rst_mid_load");
        @(negedge clk);
        rst = 1'b1;
        m.mem_rvalid = 1; m.mem_rdata = 16'hDEAD;
        do_op("late_rvalid", 0, 0, 1, 1, 1, 16'h0444, 16'h0, 16'h0088, 3'd3, 0, 0, 16'h0);
        m.mem_rvalid = 0;
        do_op("load_after_rst", 1, 0, 1, 1, 0, 16'h0500, 16'h0, 16'h0099, 3'd5, 0, 0, 16'h3C3C);

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            do_op($sformatf("rand%0d", i), (kind == 2) || (kind == 3), (kind == 1) || (kind == 3),
                  1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                  16'($urandom), 3'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                  16'($urandom));
        end

        rd_mem_en = 0; wr_mem_en = 0;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
